// File: rtl/sram_like_arbiter_pkg.sv
// Shared definitions for the SRAM-like arbiter: transfer size codes, channel roles, width helpers.
package sram_like_arbiter_pkg;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

   localparam int CH_INST = 0;
   localparam int CH_DATA = 1;

   localparam int DEF_N_CH  = 2;
   localparam int DEF_DEPTH = 4;

   // Channel id width; never below one bit so single-id storage stays legal.
   function automatic int id_w(input int n_ch);
      return (n_ch > 1) ? $clog2(n_ch) : 1;
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/sram_like_arbiter_id_fifo.sv
// Outstanding-request id FIFO: remembers which channel each accepted request belongs to, in issue order.
module sram_arb_id_fifo
   import sram_like_arbiter_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int IDW   = 1
)
(
   input  logic           clk,
   input  logic           rst,
   input  logic           push,
   input  logic           pop,
   input  logic [IDW-1:0] din,
   output logic           full,
   output logic           empty,
   output logic [IDW-1:0] head
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   logic [IDW-1:0] mem [DEPTH];
   logic [PW-1:0]  rd_ptr;
   logic [PW-1:0]  wr_ptr;
   logic [CW-1:0]  count;
   logic           push_ok;
   logic           pop_ok;

   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   // DEPTH is a power of two, so pointers wrap naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         if (push_ok && !pop_ok)      count <= count + 1'b1;
         else if (pop_ok && !push_ok) count <= count - 1'b1;
      end
   end

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

endmodule

// File: rtl/sram_like_arbiter.sv
// N-channel SRAM-like request arbiter with in-order response routing.
// Define SRAM_ARB_ROUND_ROBIN_EN for rotating priority; default is fixed priority (channel 0 highest).
//
// state | meaning
// IDLE  | grant follows the arbiter winner each cycle
// HOLD  | downstream stalled a request; grant frozen on lock_id until m_addr_ok
module sram_like_arbiter
   import sram_like_arbiter_pkg::*;
#(
   parameter int N_CH  = DEF_N_CH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = 32,
   parameter int DW    = 32
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic [N_CH-1:0]   s_req,
   input  logic [N_CH-1:0]   s_wr,
   input  logic [2*N_CH-1:0] s_size,
   input  logic [AW*N_CH-1:0] s_addr,
   input  logic [DW*N_CH-1:0] s_wdata,
   output logic [N_CH-1:0]   s_addr_ok,
   output logic [N_CH-1:0]   s_data_ok,
   output logic [DW-1:0]     s_rdata,
   output logic              m_req,
   output logic              m_wr,
   output logic [1:0]        m_size,
   output logic [AW-1:0]     m_addr,
   output logic [DW-1:0]     m_wdata,
   input  logic              m_addr_ok,
   input  logic              m_data_ok,
   input  logic [DW-1:0]     m_rdata,
   output logic              proto_err
);

   localparam int IDW = id_w(N_CH);

   typedef enum logic {IDLE, HOLD} lock_t;

   lock_t          state;
   logic [IDW-1:0] lock_id;
   logic [IDW-1:0] winner;
   logic [IDW-1:0] grant;
   logic [IDW-1:0] head;
   logic           full;
   logic           empty;
   logic           run;
   logic           accept;
   logic           pop;

   logic [1:0]    size_ch  [N_CH];
   logic [AW-1:0] addr_ch  [N_CH];
   logic [DW-1:0] wdata_ch [N_CH];

   for (genvar c = 0; c < N_CH; c++) begin : g_unpack
      assign size_ch[c]  = s_size[c*2 +: 2];
      assign addr_ch[c]  = s_addr[c*AW +: AW];
      assign wdata_ch[c] = s_wdata[c*DW +: DW];
   end

`ifdef SRAM_ARB_ROUND_ROBIN_EN
   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] rr_idx;

   // Scan from rr_ptr upward; the last hit in a descending loop is the nearest one.
   always_comb begin
      winner = '0;
      rr_idx = '0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         rr_idx = IDW'((int'(rr_ptr) + k) % N_CH);
         if (s_req[rr_idx]) winner = rr_idx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         rr_ptr <= '0;
      else if (accept) rr_ptr <= (grant == IDW'(N_CH - 1)) ? '0 : grant + 1'b1;
   end
`else
   always_comb begin
      winner = '0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         if (s_req[IDW'(k)]) winner = IDW'(k);
      end
   end
`endif

   assign run    = ~rst;
   assign grant  = (state == HOLD) ? lock_id : winner;
   assign m_req  = run & (|s_req) & ~full;
   assign accept = m_req & m_addr_ok;
   assign pop    = m_data_ok & ~empty;

   assign m_wr    = run & s_wr[grant];
   assign m_size  = run ? size_ch[grant]  : '0;
   assign m_addr  = run ? addr_ch[grant]  : '0;
   assign m_wdata = run ? wdata_ch[grant] : '0;
   assign s_rdata = m_rdata;

   always_comb begin
      s_addr_ok = '0;
      s_data_ok = '0;
      if (accept) s_addr_ok[grant] = 1'b1;
      if (pop)    s_data_ok[head]  = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         lock_id <= '0;
      end else begin
         case (state)
            IDLE: if (m_req && !m_addr_ok) begin
               state   <= HOLD;
               lock_id <= grant;
            end
            HOLD: if (accept) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    proto_err <= 1'b0;
      else if (m_data_ok && empty) proto_err <= 1'b1;
   end

   sram_arb_id_fifo #(.DEPTH(DEPTH), .IDW(IDW)) u_id_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (accept),
      .pop   (pop),
      .din   (grant),
      .full  (full),
      .empty (empty),
      .head  (head)
   );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed and randomized checks of sram_like_arbiter against a queue-based reference model.
module tb_sram_like_arbiter;

   localparam int N_CH  = 3;
   localparam int DEPTH = 4;
   localparam int AW    = 32;
   localparam int DW    = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic [N_CH-1:0]   s_req;
   logic [N_CH-1:0]   s_wr;
   logic [2*N_CH-1:0] s_size;
   logic [AW*N_CH-1:0] s_addr;
   logic [DW*N_CH-1:0] s_wdata;
   logic [N_CH-1:0]   s_addr_ok;
   logic [N_CH-1:0]   s_data_ok;
   logic [DW-1:0]     s_rdata;
   logic              m_req;
   logic              m_wr;
   logic [1:0]        m_size;
   logic [AW-1:0]     m_addr;
   logic [DW-1:0]     m_wdata;
   logic              m_addr_ok;
   logic              m_data_ok;
   logic [DW-1:0]     m_rdata;
   logic              proto_err;

   sram_like_arbiter #(.N_CH(N_CH), .DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst), .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr),
      .s_wdata(s_wdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
      .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: outstanding channel ids in issue order, lock owner, top-priority channel.
   int q[$];
   int lock_ch = -1;
   int rr = 0;
   bit perr = 1'b0;
   int e_g;
   bit e_mreq, e_acc, e_pop, e_perr;
   logic [N_CH-1:0] e_aok;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      q.delete();
      lock_ch = -1;
      rr      = 0;
      perr    = 1'b0;
      e_aok   = '0;
   endtask

   // Compute expected outputs from current inputs and model state, compare at the falling edge.
   task automatic settle();
      @(negedge clk);
      e_g = 0;
      if (lock_ch >= 0) e_g = lock_ch;
      else begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
         for (int k = N_CH - 1; k >= 0; k--) if (s_req[(rr + k) % N_CH]) e_g = (rr + k) % N_CH;
`else
         for (int k = N_CH - 1; k >= 0; k--) if (s_req[k]) e_g = k;
`endif
      end
      e_mreq = (|s_req) && (q.size() < DEPTH);
      e_acc  = e_mreq && m_addr_ok;
      e_pop  = m_data_ok && (q.size() > 0);
      e_perr = m_data_ok && (q.size() == 0);
      e_aok  = '0;
      if (e_acc) e_aok[e_g] = 1'b1;
      chk("m_req", m_req, e_mreq);
      if (e_mreq) begin
         chk("m_addr", m_addr, s_addr[e_g*AW +: AW]);
         chk("m_wdata", m_wdata, s_wdata[e_g*DW +: DW]);
         chk("m_wr", m_wr, s_wr[e_g]);
         chk("m_size", m_size, s_size[e_g*2 +: 2]);
      end
      chk("s_addr_ok", s_addr_ok, e_aok);
      chk("s_data_ok", s_data_ok, e_pop ? (64'd1 << q[0]) : 64'd0);
      chk("s_rdata", s_rdata, m_rdata);
      chk("proto_err", proto_err, perr);
   endtask

   task automatic tick();
      @(posedge clk);
      if (e_pop) void'(q.pop_front());
      if (e_acc) begin
         q.push_back(e_g);
         rr = (e_g + 1) % N_CH;
      end
      if (e_perr) perr = 1'b1;
      if (e_mreq && !m_addr_ok) lock_ch = e_g;
      else if (e_acc)           lock_ch = -1;
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      s_req = '0; m_addr_ok = 1'b0; m_data_ok = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      s_req = '1; s_wr = '0; s_size = '0; m_addr_ok = 1'b1; m_data_ok = 1'b0; m_rdata = '0;
      s_addr  = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000};
      s_wdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
      model_clear();

      // Reset state: outputs quiet even with requests presented.
      @(negedge clk);
      chk("rst_m_req", m_req, 1'b0);
      chk("rst_s_addr_ok", s_addr_ok, 3'b000);
      chk("rst_s_data_ok", s_data_ok, 3'b000);
      chk("rst_m_addr", m_addr, 32'h0);
      chk("rst_proto_err", proto_err, 1'b0);
      apply_reset();

      // Single read on channel 1.
      s_req = 3'b010; s_wr = 3'b000; s_addr[1*AW +: AW] = 32'h1FC0_0010; m_addr_ok = 1'b0;
      settle();
      chk("t1_m_addr", m_addr, 32'h1FC0_0010);
      chk("t1_wait_aok", s_addr_ok, 3'b000);
      tick();
      m_addr_ok = 1'b1;
      settle();
      chk("t1_aok", s_addr_ok, 3'b010);
      tick();
      s_req = '0; m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'hDEAD_BEEF;
      settle();
      chk("t1_dok", s_data_ok, 3'b010);
      chk("t1_rdata", s_rdata, 32'hDEAD_BEEF);
      tick();
      m_data_ok = 1'b0;

      // Simultaneous requests: channel 0 first, responses routed in order.
      s_req = 3'b011; m_addr_ok = 1'b1;
      settle(); chk("t2_first", s_addr_ok, 3'b001); tick();
      s_req = 3'b010;
      settle(); chk("t2_second", s_addr_ok, 3'b010); tick();
      s_req = '0; m_addr_ok = 1'b0; m_data_ok = 1'b1;
      settle(); chk("t2_ret0", s_data_ok, 3'b001); tick();
      settle(); chk("t2_ret1", s_data_ok, 3'b010); tick();
      m_data_ok = 1'b0;

      // Lock: channel 1 stalled three cycles while channel 0 arrives.
      s_addr[0*AW +: AW] = 32'h0000_0A00; s_addr[1*AW +: AW] = 32'h0000_0A01;
      s_req = 3'b010; m_addr_ok = 1'b0;
      settle(); chk("t3_c0", m_addr, 32'h0000_0A01); tick();
      s_req = 3'b011;
      settle(); chk("t3_c1", m_addr, 32'h0000_0A01); tick();
      settle(); chk("t3_c2", m_addr, 32'h0000_0A01); tick();
      m_addr_ok = 1'b1;
      settle(); chk("t3_acc1", s_addr_ok, 3'b010); tick();
      s_req = 3'b001;
      settle(); chk("t3_acc0", s_addr_ok, 3'b001); chk("t3_addr0", m_addr, 32'h0000_0A00); tick();
      s_req = '0; m_addr_ok = 1'b0; m_data_ok = 1'b1;
      repeat (2) begin settle(); tick(); end
      m_data_ok = 1'b0;

      // Full FIFO blocks requests, including on the cycle a response pops.
      s_req = 3'b001; m_addr_ok = 1'b1;
      repeat (DEPTH) begin settle(); tick(); end
      settle(); chk("t4_full", m_req, 1'b0); chk("t4_full_aok", s_addr_ok, 3'b000); tick();
      m_data_ok = 1'b1;
      settle(); chk("t4_pop_nobypass", m_req, 1'b0); chk("t4_pop", s_data_ok, 3'b001); tick();
      m_data_ok = 1'b0;
      settle(); chk("t4_reopen", m_req, 1'b1); chk("t4_reopen_aok", s_addr_ok, 3'b001); tick();
      s_req = '0; m_data_ok = 1'b1;
      repeat (DEPTH) begin settle(); tick(); end
      m_data_ok = 1'b0;

      // Protocol error on empty response, then reset mid-burst.
      m_data_ok = 1'b1;
      settle(); chk("t5_no_dok", s_data_ok, 3'b000); tick();
      m_data_ok = 1'b0;
      settle(); chk("t5_perr", proto_err, 1'b1); tick();
      settle(); chk("t5_perr_sticky", proto_err, 1'b1); tick();
      s_req = 3'b001; m_addr_ok = 1'b1;
      repeat (2) begin settle(); tick(); end
      rst = 1'b1; m_data_ok = 1'b1;
      #1;
      chk("t5_rst_m_req", m_req, 1'b0);
      chk("t5_rst_aok", s_addr_ok, 3'b000);
      chk("t5_rst_dok", s_data_ok, 3'b000);
      chk("t5_rst_perr", proto_err, 1'b0);
      model_clear();
      @(posedge clk); #1;
      rst = 1'b0; s_req = '0; m_addr_ok = 1'b0;
      settle(); chk("t5_inflight_dok", s_data_ok, 3'b000); tick();
      m_data_ok = 1'b0;
      settle(); chk("t5_inflight_perr", proto_err, 1'b1); tick();
      apply_reset();

      // All channels requesting with immediate accept.
      s_req = 3'b111; m_addr_ok = 1'b1;
      for (int i = 0; i < 6; i++) begin
         int exp_ch;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
         exp_ch = i % N_CH;
`else
         exp_ch = 0;
`endif
         settle(); chk("t6_grant", s_addr_ok, 64'd1 << exp_ch); tick();
         m_data_ok = 1'b1;
      end
      s_req = '0; m_addr_ok = 1'b0;
      settle(); tick();
      m_data_ok = 1'b0;

      // Randomized traffic; masters hold request fields until accepted.
      for (int n = 0; n < 2000; n++) begin
         for (int c = 0; c < N_CH; c++) begin
            if (!(s_req[c] && !e_aok[c])) begin
               s_req[c] = ($urandom_range(0, 2) == 0);
               s_wr[c] = 1'($urandom_range(0, 1));
               s_size[c*2 +: 2] = 2'($urandom_range(0, 2));
               s_addr[c*AW +: AW] = $urandom;
               s_wdata[c*DW +: DW] = $urandom;
            end
         end
         m_addr_ok = 1'($urandom_range(0, 1));
         m_data_ok = (q.size() > 0) && ($urandom_range(0, 2) != 0);
         m_rdata = $urandom;
         settle();
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
